// File: rtl/prpg_multimode.sv
// prpg_multimode - multi-mode pseudo-random pattern generator for the BIST
// pattern path. It produces Fibonacci LFSR, Galois LFSR, hybrid rule-90/150
// cellular automaton or binary counter sequences. Each run is bounded to
// NUM_PATTERNS patterns and ends with a sticky done flag.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous active-high reset
//   load       load seed (any state), returns to IDLE
//   seed       seed value for load
//   mode       00 Fibonacci, 01 Galois, 10 CA, 11 counter (captured on start)
//   start      begin a run from IDLE or DONE
//   en         advance enable while running
//   out        current pattern
//   valid      high while running, out is a test pattern
//   done       sticky run-complete flag
//   pat_count  patterns consumed in the current run
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | seeded or reset, out holds, waiting for start
// RUN   | valid=1, each en-high cycle consumes one pattern
// DONE  | NUM_PATTERNS consumed, done=1, out holds
module prpg_multimode #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] CA_RULE      = 8'h00,
  parameter logic [WIDTH-1:0] RESET_SEED   = 8'h01,
  parameter int               NUM_PATTERNS = 255,
  parameter int               CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             done,
  output logic [CNT_W-1:0] pat_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  state_t           state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH+1:0] ca_ext;
  logic [WIDTH-1:0] seed_fix;

  always_comb begin
    nxt    = out;
    ca_ext = {1'b0, out, 1'b0};   // null boundary cells on both ends
    case (mode_q)
      2'b00: nxt = {out[WIDTH-2:0], ^(out & TAPS)};
      2'b01: nxt = (out >> 1) ^ (out[0] ? TAPS : '0);
      2'b10: begin
        // ca_ext[i] is out[i-1], ca_ext[i+2] is out[i+1]
        for (int i = 0; i < WIDTH; i++) begin
          nxt[i] = ca_ext[i] ^ ca_ext[i+2] ^ (CA_RULE[i] & out[i]);
        end
      end
      default: nxt = out + WIDTH'(1);
    endcase
  end

  // All-zero is a lock-up state for the LFSR/CA modes. The mode for the next
  // run is not known yet at load time, so a zero seed is only kept when both
  // the presented mode and the last captured mode are the counter.
  always_comb begin
    seed_fix = seed;
    if (seed == '0 && (mode != 2'b11 || mode_q != 2'b11)) begin
      seed_fix = WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out       <= RESET_SEED;
      pat_count <= '0;
      state     <= IDLE;
      valid     <= 1'b0;
      done      <= 1'b0;
      mode_q    <= 2'b00;
    end else if (load) begin
      out       <= seed_fix;
      pat_count <= '0;
      state     <= IDLE;
      valid     <= 1'b0;
      done      <= 1'b0;
    end else if (start && state != RUN) begin
      // out is not advanced: the first pattern of the run is the current value
      mode_q    <= mode;
      pat_count <= '0;
      state     <= RUN;
      valid     <= 1'b1;
      done      <= 1'b0;
    end else if (state == RUN && en) begin
      if (pat_count == LAST_CNT) begin
        state <= DONE;
        valid <= 1'b0;
        done  <= 1'b1;
      end else begin
        out       <= nxt;
        pat_count <= pat_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_prpg_multimode.sv
// tb_prpg_multimode - directed vector table plus hand-written sequences for
// prpg_multimode with default parameters (8-bit, TAPS B8, 255 patterns).
module tb_prpg_multimode;

  logic        clk;
  logic        reset;
  logic        load;
  logic [7:0]  seed;
  logic [1:0]  mode;
  logic        start;
  logic        en;
  logic [7:0]  out;
  logic        valid;
  logic        done;
  logic [15:0] pat_count;

  int n_checks = 0;
  int n_fail   = 0;

  prpg_multimode dut (
    .clk(clk), .reset(reset), .load(load), .seed(seed), .mode(mode),
    .start(start), .en(en), .out(out), .valid(valid), .done(done),
    .pat_count(pat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ld;
    logic [7:0]  sd;
    logic [1:0]  md;
    logic        st;
    logic        e;
    logic [7:0]  x_out;
    logic        x_valid;
    logic        x_done;
    logic [15:0] x_cnt;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic ld, logic [7:0] sd, logic [1:0] md,
                              logic st, logic e, logic [7:0] xo, logic xv,
                              logic xd, logic [15:0] xc);
    vec_t v;
    v.rst = rst; v.ld = ld; v.sd = sd; v.md = md; v.st = st; v.e = e;
    v.x_out = xo; v.x_valid = xv; v.x_done = xd; v.x_cnt = xc;
    return v;
  endfunction

  // Reference Fibonacci step for TAPS = B8 (stages 7,5,4,3)
  function automatic logic [7:0] fib(logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic rst, logic ld, logic [7:0] sd, logic [1:0] md,
                       logic st, logic e);
    reset = rst; load = ld; seed = sd; mode = md; start = st; en = e;
  endtask

  logic [255:0] seen;
  logic [7:0]   exp_v;
  logic [7:0]   last_v;
  int           n_rec;
  int           n_dup;
  int           n_zero;
  int           n_seq_err;
  bit           got_done;

  initial begin
    drive(0, 0, 8'h00, 2'b00, 0, 0);

    //            rst ld seed   md    st e   out    v  d  cnt
    vecs[0]  = mk(1, 0, 8'h00, 2'b00, 0, 0, 8'h01, 0, 0, 0);
    vecs[1]  = mk(0, 1, 8'h01, 2'b00, 0, 0, 8'h01, 0, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 2'b00, 1, 0, 8'h01, 1, 0, 0);
    vecs[3]  = mk(0, 0, 8'h00, 2'b00, 0, 1, 8'h02, 1, 0, 1);
    vecs[4]  = mk(0, 0, 8'h00, 2'b00, 0, 1, 8'h04, 1, 0, 2);
    vecs[5]  = mk(0, 0, 8'h00, 2'b00, 0, 1, 8'h08, 1, 0, 3);
    vecs[6]  = mk(0, 0, 8'h00, 2'b00, 0, 1, 8'h11, 1, 0, 4);
    vecs[7]  = mk(0, 0, 8'h00, 2'b00, 0, 1, 8'h23, 1, 0, 5);
    vecs[8]  = mk(0, 0, 8'h00, 2'b00, 0, 0, 8'h23, 1, 0, 5);
    vecs[9]  = mk(0, 1, 8'h01, 2'b01, 0, 0, 8'h01, 0, 0, 0);
    vecs[10] = mk(0, 0, 8'h00, 2'b01, 1, 0, 8'h01, 1, 0, 0);
    vecs[11] = mk(0, 0, 8'h00, 2'b01, 0, 1, 8'hB8, 1, 0, 1);
    vecs[12] = mk(0, 0, 8'h00, 2'b01, 0, 1, 8'h5C, 1, 0, 2);
    vecs[13] = mk(0, 0, 8'h00, 2'b01, 0, 1, 8'h2E, 1, 0, 3);
    vecs[14] = mk(0, 0, 8'h00, 2'b01, 0, 1, 8'h17, 1, 0, 4);
    vecs[15] = mk(0, 0, 8'h00, 2'b01, 0, 1, 8'hB3, 1, 0, 5);
    vecs[16] = mk(0, 1, 8'h01, 2'b10, 0, 0, 8'h01, 0, 0, 0);
    vecs[17] = mk(0, 0, 8'h00, 2'b10, 1, 0, 8'h01, 1, 0, 0);
    vecs[18] = mk(0, 0, 8'h00, 2'b10, 0, 1, 8'h02, 1, 0, 1);
    vecs[19] = mk(0, 0, 8'h00, 2'b10, 0, 1, 8'h05, 1, 0, 2);
    vecs[20] = mk(0, 1, 8'h00, 2'b00, 0, 0, 8'h01, 0, 0, 0);
    vecs[21] = mk(0, 1, 8'hFF, 2'b11, 0, 0, 8'hFF, 0, 0, 0);
    vecs[22] = mk(0, 0, 8'h00, 2'b11, 1, 0, 8'hFF, 1, 0, 0);
    vecs[23] = mk(0, 0, 8'h00, 2'b11, 0, 1, 8'h00, 1, 0, 1);
    vecs[24] = mk(0, 0, 8'h00, 2'b11, 0, 1, 8'h01, 1, 0, 2);
    vecs[25] = mk(0, 1, 8'h00, 2'b11, 0, 0, 8'h00, 0, 0, 0);
    vecs[26] = mk(0, 0, 8'h00, 2'b11, 1, 0, 8'h00, 1, 0, 0);
    vecs[27] = mk(0, 0, 8'h00, 2'b00, 1, 1, 8'h01, 1, 0, 1);
    vecs[28] = mk(1, 1, 8'h77, 2'b01, 1, 1, 8'h01, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].sd, vecs[i].md, vecs[i].st, vecs[i].e);
      tick();
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].x_out));
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].x_valid));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].x_done));
      chk($sformatf("vec%0d_cnt", i), 32'(pat_count), 32'(vecs[i].x_cnt));
    end

    // Full 255-pattern Fibonacci run with en toggling every other cycle
    drive(0, 1, 8'h01, 2'b00, 0, 0); tick();
    drive(0, 0, 8'h00, 2'b00, 1, 0); tick();
    start = 0;
    seen = '0; n_rec = 0; n_dup = 0; n_zero = 0; n_seq_err = 0;
    got_done = 0; exp_v = 8'h01; last_v = 8'h00;
    for (int i = 0; i < 1200 && !got_done; i++) begin
      en = (i % 2 == 0);
      if (valid && en) begin
        if (out == 8'h00) n_zero++;
        else if (seen[out]) n_dup++;
        if (out != exp_v) n_seq_err++;
        seen[out] = 1'b1;
        n_rec++;
        last_v = out;
        exp_v = fib(exp_v);
      end
      tick();
      if (done) got_done = 1;
    end
    en = 0;
    chk("run_done_reached", 32'(got_done), 32'd1);
    chk("run_pattern_count", 32'(n_rec), 32'd255);
    chk("run_duplicates", 32'(n_dup), 32'd0);
    chk("run_zero_patterns", 32'(n_zero), 32'd0);
    chk("run_sequence_errors", 32'(n_seq_err), 32'd0);
    chk("run_end_valid", 32'(valid), 32'd0);
    chk("run_end_out_held", 32'(out), 32'(last_v));

    en = 1; tick();
    chk("done_sticky", 32'(done), 32'd1);
    chk("done_out_hold", 32'(out), 32'(last_v));
    en = 0;

    // Restart from DONE continues from the held value
    drive(0, 0, 8'h00, 2'b00, 1, 0); tick();
    start = 0;
    chk("restart_valid", 32'(valid), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_out", 32'(out), 32'(last_v));
    chk("restart_cnt", 32'(pat_count), 32'd0);
    en = 1; tick();
    exp_v = fib(last_v);
    chk("restart_step", 32'(out), 32'(exp_v));

    // Mode input changes mid-run must not affect the sequence
    mode = 2'b01;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_v = fib(exp_v);
    end
    en = 0;
    chk("modechg_out", 32'(out), 32'(exp_v));
    chk("modechg_cnt", 32'(pat_count), 32'd10);

    // Mid-run load aborts with no done pulse
    drive(0, 1, 8'h5A, 2'b00, 0, 0); tick();
    load = 0;
    chk("abort_out", 32'(out), 32'h5A);
    chk("abort_valid", 32'(valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_cnt", 32'(pat_count), 32'd0);

    // Reset mid-run overrides load and start
    drive(0, 0, 8'h00, 2'b00, 1, 0); tick();
    drive(0, 0, 8'h00, 2'b00, 0, 1); tick(); tick(); tick();
    chk("prereset_cnt", 32'(pat_count), 32'd3);
    drive(1, 1, 8'h33, 2'b10, 1, 1); tick();
    chk("rst_out", 32'(out), 32'h01);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(pat_count), 32'd0);
    drive(0, 0, 8'h00, 2'b00, 0, 0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
